// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, combinational instruction memory read,
// and the IF/ID pipeline register with stall, flush and redirect handling.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic [31:0] fetch_count_o
);

  localparam int unsigned AW  = $clog2(IMEM_WORDS);
  localparam logic [31:0] NOP = 32'h00000013;

  // Contents are loaded externally by the bench; never cleared by reset.
  logic [31:0] mem [IMEM_WORDS];

  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   pc_plus4;
  logic [31:0]   fetch_word;
  logic [AW-1:0] fetch_idx;

  // Word index ignores PC bits above the memory size, so fetches wrap.
  always_comb begin
    pc_plus4   = pc + 32'd4;
    fetch_idx  = pc[AW+1:2];
    fetch_word = mem[fetch_idx];
  end

  // Next PC: redirect beats stall beats sequential.
  always_comb begin
    pc_next = pc_plus4;
    if (redirect_i) begin
      pc_next = redirect_pc_i & ~32'h00000003;
    end else if (stall_i) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // IF/ID register; a bubble keeps the old pc/pc4 and only swaps in a NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id_pc_o    <= 32'h00000000;
      if_id_pc4_o   <= 32'h00000000;
      if_id_instr_o <= NOP;
      if_id_valid_o <= 1'b0;
      fetch_count_o <= 32'h00000000;
    end else if (redirect_i || flush_i) begin
      if_id_instr_o <= NOP;
      if_id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if_id_pc_o    <= pc;
      if_id_pc4_o   <= pc_plus4;
      if_id_instr_o <= fetch_word;
      if_id_valid_o <= 1'b1;
      fetch_count_o <= fetch_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed control sequences checked against a behavioural
// fetch model every cycle, plus literal expectations at key points.
module tb_if_stage;

  localparam int unsigned WORDS = 256;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic [31:0] fetch_count_o;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  logic [31:0] img [WORDS];

  // Model state: what the stage must show, derived from the fetch rules.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  logic        m_valid;

  if_stage #(.RESET_PC(32'h00000000), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_id_pc_o(if_id_pc_o), .if_id_pc4_o(if_id_pc4_o),
    .if_id_instr_o(if_id_instr_o), .if_id_valid_o(if_id_valid_o),
    .fetch_count_o(fetch_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin : model
    logic [31:0] word;
    if (!rst) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
      m_instr = NOP; m_valid = 1'b0; m_cnt = 32'h0;
    end else begin
      word = img[(m_pc / 4) % WORDS];
      if (redirect_i || flush_i) begin
        m_instr = NOP;
        m_valid = 1'b0;
      end else if (!stall_i) begin
        m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
        m_instr = word; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end
      if (redirect_i) m_pc = {redirect_pc_i[31:2], 2'b00};
      else if (!stall_i) m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("pc", if_id_pc_o, m_ipc);
      chk("pc4", if_id_pc4_o, m_ipc4);
      chk("instr", if_id_instr_o, m_instr);
      chk("valid", 32'(if_id_valid_o), 32'(m_valid));
      chk("count", fetch_count_o, m_cnt);
      chk("fetch_pc", dut.pc, m_pc);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ctl(input logic s, input logic f, input logic r, input logic [31:0] t);
    stall_i = s; flush_i = f; redirect_i = r; redirect_pc_i = t;
  endtask

  task automatic lit(input string name, input logic [31:0] pc, input logic [31:0] instr,
                     input logic v, input logic [31:0] cnt);
    chk({name, "_pc"}, if_id_pc_o, pc);
    chk({name, "_instr"}, if_id_instr_o, instr);
    chk({name, "_valid"}, 32'(if_id_valid_o), 32'(v));
    chk({name, "_cnt"}, fetch_count_o, cnt);
  endtask

  initial begin
    rst = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < int'(WORDS); i++) img[i] = 32'h10000000 + 32'(i);
    img[0] = 32'hAAAA0000; img[1] = 32'hBBBB0001;
    img[2] = 32'hCCCC0002; img[3] = 32'hDDDD0003;
    img[8] = 32'h88880008; img[255] = 32'hFFFF00FF;
    for (int i = 0; i < int'(WORDS); i++) dut.mem[i] = img[i];

    edges(2);
    lit("reset", 32'h0, NOP, 1'b0, 32'h0);
    chk("reset_pc4", if_id_pc4_o, 32'h0);
    run_cmp = 1'b1;
    rst = 1'b1;

    edges(1); lit("seqA", 32'h0, 32'hAAAA0000, 1'b1, 32'd1);
    edges(1); lit("seqB", 32'h4, 32'hBBBB0001, 1'b1, 32'd2);
    ctl(1'b1, 1'b0, 1'b0, 32'h0);
    edges(2); lit("stall", 32'h4, 32'hBBBB0001, 1'b1, 32'd2);
    chk("stall_pc", dut.pc, 32'h8);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    edges(1); lit("seqC", 32'h8, 32'hCCCC0002, 1'b1, 32'd3);
    edges(1); lit("seqD", 32'hC, 32'hDDDD0003, 1'b1, 32'd4);
    chk("seqD_pc4", if_id_pc4_o, 32'h10);

    ctl(1'b1, 1'b0, 1'b1, 32'h23);
    edges(1); lit("redir", 32'hC, NOP, 1'b0, 32'd4);
    chk("redir_pc", dut.pc, 32'h20);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    edges(1); lit("redir_tgt", 32'h20, 32'h88880008, 1'b1, 32'd5);

    ctl(1'b0, 1'b1, 1'b0, 32'h0);
    edges(1); lit("flush", 32'h20, NOP, 1'b0, 32'd5);
    chk("flush_pc", dut.pc, 32'h28);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    edges(1); lit("post_flush", 32'h28, 32'h1000000A, 1'b1, 32'd6);

    ctl(1'b1, 1'b1, 1'b0, 32'h0);
    edges(1); chk("flush_stall_pc", dut.pc, 32'h2C);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    edges(1); lit("post_fs", 32'h2C, 32'h1000000B, 1'b1, 32'd7);

    ctl(1'b0, 1'b0, 1'b1, 32'h3FE);
    edges(1); chk("wrap_redir_pc", dut.pc, 32'h3FC);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    edges(1); lit("wrap_last", 32'h3FC, 32'hFFFF00FF, 1'b1, 32'd8);
    edges(1); lit("wrap_first", 32'h400, 32'hAAAA0000, 1'b1, 32'd9);
    chk("wrap_pc4", if_id_pc4_o, 32'h404);

    // Mixed control pattern table: {stall, flush, redirect}.
    for (int k = 0; k < 24; k++) begin
      logic [2:0] pat [8];
      pat[0] = 3'b000; pat[1] = 3'b100; pat[2] = 3'b010; pat[3] = 3'b000;
      pat[4] = 3'b001; pat[5] = 3'b110; pat[6] = 3'b101; pat[7] = 3'b011;
      ctl(pat[k % 8][2], pat[k % 8][1], pat[k % 8][0], 32'h00000100 + 32'(k * 13));
      edges(1);
    end
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    edges(3);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    lit("async_rst", 32'h0, NOP, 1'b0, 32'h0);
    chk("async_rst_pc4", if_id_pc4_o, 32'h0);
    chk("async_rst_fpc", dut.pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    edges(1); lit("restart", 32'h0, 32'hAAAA0000, 1'b1, 32'd1);
    edges(1); lit("restart2", 32'h4, 32'hBBBB0001, 1'b1, 32'd2);

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
